control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: Clock and Clear.
REQ-002 The ports SHALL be:
- Clock  in  1  rising-edge clock.
- Clear  in  1  synchronous active-high reset.
- IR  in  32  instruction register contents from the datapath.
- Stop  in  1  halt request, level-sensitive.
- PCout, Zlowout, ZHighout, HIout, LOout, MDRout  out  1 each  bus drive enables.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin  out  1 each  register load enables.
- IncPC, Read  out  1 each  PC increment select; memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and general-register in/out strobes.
- ALU_op  out  5  ALU operation code.
- Run  out  1  high while executing.

Function
REQ-003 State set SHALL be: RESET, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-004 Outputs SHALL be Moore, decoded from the current state and IR[31:27]. Any output not listed for a state SHALL be 0.
REQ-005 Opcode = IR[31:27]; field decode (Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]) is done in the datapath, selected by Gra/Grb/Grc.
REQ-006 Opcode map:
- add 01000, sub 01001, and 01010, or 01011, shr 01100, shl 01101, ror 01110, rol 01111 (ALU class).
- mul 10000, div 10001 (MULDIV class).
- halt 11011.
- All other codes are nop.
REQ-007 RESET: all controls 0, Run = 0; next state T0.
REQ-008 T0: PCout, MARin, IncPC, ZLowIn; next state is T1, or HALT if Stop = 1.
REQ-009 T1: Zlowout, PCin, Read, MDRin; next state T2.
REQ-010 T2: MDRout, IRin; next state T3.
REQ-011 T3 by class:
- ALU/MULDIV: Grb, Rout, Yin; next state T4.
- halt: no controls; next state HALT.
- nop: no controls; next state T0.
REQ-012 T4: Grc, Rout, ZLowIn, ALU_op = opcode. ZHighIn is additionally asserted for the MULDIV class. Next state T5.
REQ-013 T5 by class:
- ALU: Zlowout, Gra, Rin; next state T0.
- MULDIV: Zlowout, LOin; next state T6.
REQ-014 T6 (MULDIV only): ZHighout, HIin; next state T0.
REQ-015 ALU_op SHALL be 00000 in every state except T4.
REQ-016 Latency, counted from T0 entry to the next T0 entry:
- ALU class: 6 cycles.
- MULDIV class: 7 cycles.
- nop: 4 cycles.
REQ-017 IR SHALL be decoded only in T3 through T6. IR changes during T0 through T2 SHALL have no effect.
REQ-018 Stop SHALL be sampled only in T0. Stop asserted mid-instruction lets the instruction complete and halts at the next T0.
REQ-019 HALT SHALL hold all controls at 0 and Run = 0. Only Clear exits HALT.
REQ-020 Run SHALL be 1 in states T0 through T6.
REQ-021 No two bus-drive outputs (PCout, Zlowout, ZHighout, HIout, LOout, MDRout, Rout) SHALL be high in the same cycle.

Reset
REQ-022 Clear = 1 at a rising edge SHALL force state RESET at that edge, from any state including mid-instruction and HALT.
REQ-023 While Clear is held, the state SHALL remain RESET and all outputs SHALL be 0.
REQ-024 The first cycle after Clear deasserts SHALL be RESET; T0 follows on the next edge.

Configuration
REQ-025 Macro MULDIV_EN, when defined: mul/div SHALL follow REQ-011 to REQ-014, and T6 SHALL exist.
REQ-026 MULDIV_EN undefined: opcodes 10000 and 10001 SHALL decode as nop, and ZHighIn, ZHighout, HIin, LOin SHALL be tied to 0.

Verification
REQ-027 Clear for 2 cycles, then IR = 0x4A920000 (sub R5,R2,R4).
- Required: RESET then T0..T5.
- T4 shows ALU_op = 01001 with Grc, Rout, ZLowIn.
- T5 shows Zlowout, Gra, Rin.
- Back to T0 after 6 cycles.
REQ-028 IR = 0x80000000 (mul) with MULDIV_EN defined.
- Required: T5 asserts LOin; T6 asserts ZHighout, HIin; 7-cycle latency.
- Same stimulus without MULDIV_EN: nop, 4-cycle latency, HIin never high.
REQ-029 IR = 0xD8000000 (halt).
- Required: HALT after T3; Run = 0 and all controls 0 for 20 cycles.
- Clear then returns to RESET.
REQ-030 Stop = 1 raised during T4 of an add.
- Required: T5 completes Rin, next T0 occurs, then HALT; no T1.
REQ-031 Clear pulsed during T4 of a sub.
- Required: next state RESET; Rin never asserted for that instruction; T0 one cycle after Clear falls.
REQ-032 Every cycle of every scenario: at most one bus-drive output high; ALU_op = 0 outside T4.

Source files
------------

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then class-dependent execute (T3-T6).
// Optional multiply/divide support is enabled by defining MULDIV_EN.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        HIout,
    output logic        LOout,
    output logic        MDRout,
    output logic        MARin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        HIin,
    output logic        LOin,
    output logic        IncPC,
    output logic        Read,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  ALU_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        StReset,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] opcode;
    logic       is_alu;
    logic       is_muldiv;
    logic       is_halt;
    logic       unused_ir;

    assign opcode = IR[31:27];
    // Register fields are decoded in the datapath, not here.
    assign unused_ir = ^IR[26:0];

    assign is_alu  = (opcode[4:3] == 2'b01);
    assign is_halt = (opcode == 5'b11011);
`ifdef MULDIV_EN
    assign is_muldiv = (opcode[4:1] == 4'b1000);
`else
    // mul/div fall through to nop, so the MULDIV-only strobes are never driven.
    assign is_muldiv = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q <= StReset;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        MDRout   = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        ALU_op   = 5'b00000;
        Run      = 1'b0;

        unique case (state_q)
            StReset: begin
                state_d = StT0;
            end
            StT0: begin
                Run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                ZLowIn  = 1'b1;
                state_d = Stop ? StHalt : StT1;
            end
            StT1: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = StT2;
            end
            StT2: begin
                Run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = StT3;
            end
            StT3: begin
                Run = 1'b1;
                if (is_alu || is_muldiv) begin
                    Grb     = 1'b1;
                    Rout    = 1'b1;
                    Yin     = 1'b1;
                    state_d = StT4;
                end else if (is_halt) begin
                    state_d = StHalt;
                end else begin
                    state_d = StT0;
                end
            end
            StT4: begin
                Run     = 1'b1;
                Grc     = 1'b1;
                Rout    = 1'b1;
                ZLowIn  = 1'b1;
                ZHighIn = is_muldiv;
                ALU_op  = opcode;
                state_d = StT5;
            end
            StT5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = StT6;
                end else begin
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    state_d = StT0;
                end
            end
            StT6: begin
                Run      = 1'b1;
                ZHighout = is_muldiv;
                HIin     = is_muldiv;
                state_d  = StT0;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StReset;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-instruction expected control-word lists built from the
// instruction class, compared every cycle on the falling clock edge.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        Stop;
    logic PCout, Zlowout, ZHighout, HIout, LOout, MDRout;
    logic MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
    logic [4:0] ALU_op;

    int total;
    int bad;
    bit ended;
    bit stop_glitch;

`ifdef MULDIV_EN
    localparam bit MdEn = 1'b1;
`else
    localparam bit MdEn = 1'b0;
`endif

    localparam logic [27:0] C_PCOUT    = 28'h1 << 27;
    localparam logic [27:0] C_ZLOWOUT  = 28'h1 << 26;
    localparam logic [27:0] C_ZHIGHOUT = 28'h1 << 25;
    localparam logic [27:0] C_MDROUT   = 28'h1 << 22;
    localparam logic [27:0] C_MARIN    = 28'h1 << 21;
    localparam logic [27:0] C_PCIN     = 28'h1 << 20;
    localparam logic [27:0] C_MDRIN    = 28'h1 << 19;
    localparam logic [27:0] C_IRIN     = 28'h1 << 18;
    localparam logic [27:0] C_YIN      = 28'h1 << 17;
    localparam logic [27:0] C_ZLOWIN   = 28'h1 << 16;
    localparam logic [27:0] C_ZHIGHIN  = 28'h1 << 15;
    localparam logic [27:0] C_HIIN     = 28'h1 << 14;
    localparam logic [27:0] C_LOIN     = 28'h1 << 13;
    localparam logic [27:0] C_INCPC    = 28'h1 << 12;
    localparam logic [27:0] C_READ     = 28'h1 << 11;
    localparam logic [27:0] C_GRA      = 28'h1 << 10;
    localparam logic [27:0] C_GRB      = 28'h1 << 9;
    localparam logic [27:0] C_GRC      = 28'h1 << 8;
    localparam logic [27:0] C_RIN      = 28'h1 << 7;
    localparam logic [27:0] C_ROUT     = 28'h1 << 6;
    localparam logic [27:0] C_RUN      = 28'h1;

    control_sequencer dut (
        .Clock    (Clock),
        .Clear    (Clear),
        .IR       (IR),
        .Stop     (Stop),
        .PCout    (PCout),
        .Zlowout  (Zlowout),
        .ZHighout (ZHighout),
        .HIout    (HIout),
        .LOout    (LOout),
        .MDRout   (MDRout),
        .MARin    (MARin),
        .PCin     (PCin),
        .MDRin    (MDRin),
        .IRin     (IRin),
        .Yin      (Yin),
        .ZLowIn   (ZLowIn),
        .ZHighIn  (ZHighIn),
        .HIin     (HIin),
        .LOin     (LOin),
        .IncPC    (IncPC),
        .Read     (Read),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .ALU_op   (ALU_op),
        .Run      (Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // 0 nop, 1 ALU, 2 mul/div, 3 halt
    function automatic int cls_of(input logic [4:0] op);
        if (op >= 5'd8 && op <= 5'd15) return 1;
        if ((op == 5'd16 || op == 5'd17) && MdEn) return 2;
        if (op == 5'd27) return 3;
        return 0;
    endfunction

    task automatic chk(input logic [27:0] exp, input string tag);
        logic [27:0] obs;
        int nbus;
        obs = {PCout, Zlowout, ZHighout, HIout, LOout, MDRout, MARin, PCin, MDRin, IRin,
               Yin, ZLowIn, ZHighIn, HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout,
               ALU_op, Run};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: controls got %h expected %h", tag, obs, exp);
        end
        nbus = $countones({PCout, Zlowout, ZHighout, HIout, LOout, MDRout, Rout});
        total++;
        assert (nbus <= 1) else begin
            bad++;
            $error("FAIL %s bus: drivers got %0d expected <=1", tag, nbus);
        end
    endtask

    // Runs one instruction from its T0; ended=1 when the stream stops (halt/stop/clear).
    task automatic do_instr(input logic [31:0] ir, input int stop_at, input int clear_at,
                            output bit ended_o);
        logic [27:0] seq[$];
        logic [4:0]  op;
        int          c;
        op = ir[31:27];
        c  = cls_of(op);
        seq = {};
        seq.push_back(C_PCOUT | C_MARIN | C_INCPC | C_ZLOWIN | C_RUN);
        seq.push_back(C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN | C_RUN);
        seq.push_back(C_MDROUT | C_IRIN | C_RUN);
        if (c == 1 || c == 2) begin
            seq.push_back(C_GRB | C_ROUT | C_YIN | C_RUN);
            seq.push_back(C_GRC | C_ROUT | C_ZLOWIN | (28'(op) << 1) | C_RUN
                          | ((c == 2) ? C_ZHIGHIN : 28'h0));
            if (c == 1) begin
                seq.push_back(C_ZLOWOUT | C_GRA | C_RIN | C_RUN);
            end else begin
                seq.push_back(C_ZLOWOUT | C_LOIN | C_RUN);
                seq.push_back(C_ZHIGHOUT | C_HIIN | C_RUN);
            end
        end else begin
            seq.push_back(C_RUN);
        end
        ended_o = 1'b0;
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge Clock);
            chk(seq[i], $sformatf("ir=%h step%0d", ir, i));
            if (i == 0 && Stop) begin
                ended_o = 1'b1;
                return;
            end
            if (i == clear_at) begin
                Clear   = 1'b1;
                ended_o = 1'b1;
                return;
            end
            if (i == stop_at) Stop = 1'b1;
            if (stop_glitch && i == 1) Stop = 1'b1;
            if (stop_glitch && i == 2) Stop = 1'b0;
            if (i < 2) IR = $urandom;
            else if (i == 2) IR = ir;
        end
        if (c == 3) ended_o = 1'b1;
    endtask

    task automatic expect_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            chk(28'h0, tag);
            IR   = $urandom;
            Stop = 1'($urandom);
        end
    endtask

    // Holds Clear for n edges; T0 is expected at the negedge after the last one.
    task automatic do_clear(input int n);
        Clear = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge Clock);
            chk(28'h0, "clear");
            IR = $urandom;
        end
        Clear = 1'b0;
        Stop  = 1'b0;
    endtask

    initial begin
        logic [4:0]  op;
        logic [31:0] ir;
        total = 0;
        bad = 0;
        stop_glitch = 1'b0;
        Clear = 1'b1;
        Stop = 1'b0;
        IR = 32'h0;

        do_clear(2);
        do_instr(32'h4A920000, -1, -1, ended);
        do_instr(32'h80000000, -1, -1, ended);
        do_instr(32'h88000000, -1, -1, ended);

        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) op = 5'($urandom_range(8, 15));
            else if ($urandom_range(0, 2) == 0) op = 5'($urandom_range(16, 17));
            if (op == 5'd27) op = 5'd0;
            ir = {op, 27'($urandom)};
            stop_glitch = 1'($urandom);
            do_instr(ir, -1, -1, ended);
        end
        stop_glitch = 1'b0;

        // Stop raised during T4 of an add: completes, one more T0, then halts.
        do_instr({5'b01000, 27'($urandom)}, 4, -1, ended);
        do_instr(32'h40000000, -1, -1, ended);
        expect_idle(10, "stop halt");
        do_clear(1);

        // Clear pulsed during T4 of a sub.
        do_instr(32'h4A920000, -1, 4, ended);
        do_clear(1);
        do_instr({5'b01011, 27'($urandom)}, -1, -1, ended);

        // Halt instruction.
        do_instr(32'hD8000000, -1, -1, ended);
        expect_idle(20, "halt hold");
        do_clear(2);
        do_instr({5'b01111, 27'($urandom)}, -1, -1, ended);
        do_instr(32'h00000000, -1, -1, ended);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
